// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer: reset, self-test/ID check, enable reporting,
// then hand the bus to the stream-mode packet datapath.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | count a new attempt, rewind the command script
// INHIBIT   | hold PS/2 clock low before request-to-send
// RTS       | clock and data low together (start bit)
// TX        | shift command, parity and stop out on device clock falls
// TX_ACK    | sample device ACK, then wait for both lines idle-high
// RX        | collect one 11-bit device frame
// CHECK     | validate the frame against the expected response byte
// DONE      | mouse streaming, bus traffic ignored
// FAIL      | all attempts exhausted
module ps2_mouse_init_ctrl #(
   parameter int unsigned INHIBIT_CYCLES      = 10000,
   parameter int unsigned RESP_TIMEOUT_CYCLES = 75000000,
   parameter int unsigned BIT_TIMEOUT_CYCLES  = 200000,
   parameter int unsigned MAX_RETRY           = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   input  logic       reinit,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       init_done,
   output logic       init_error,
   output logic       datapath_rst,
   output logic [3:0] attempt_cnt,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_INHIBIT = 4'd1,
      S_RTS     = 4'd2,
      S_TX      = 4'd3,
      S_TX_ACK  = 4'd4,
      S_RX      = 4'd5,
      S_CHECK   = 4'd6,
      S_DONE    = 4'd7,
      S_FAIL    = 4'd8
   } state_t;

   localparam logic [31:0] INHIBIT_LAST = 32'(INHIBIT_CYCLES - 1);
   localparam logic [31:0] RESP_LAST    = 32'(RESP_TIMEOUT_CYCLES - 1);
   localparam logic [31:0] BIT_LAST     = 32'(BIT_TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);
   localparam logic [2:0]  LAST_STEP    = 3'd5;

   // Script: FF -> FA AA 00, F4 -> FA
   function automatic logic [7:0] script_byte(input logic [2:0] s);
      case (s)
         3'd0:    script_byte = 8'hFF;
         3'd1:    script_byte = 8'hFA;
         3'd2:    script_byte = 8'hAA;
         3'd3:    script_byte = 8'h00;
         3'd4:    script_byte = 8'hF4;
         3'd5:    script_byte = 8'hFA;
         default: script_byte = 8'h00;
      endcase
   endfunction

   function automatic logic script_is_cmd(input logic [2:0] s);
      script_is_cmd = (s == 3'd0) || (s == 3'd4);
   endfunction

   state_t      state_q, state_d;
   logic [1:0]  clk_sync, data_sync;
   logic        clk_prev;
   logic        clk_s, data_s, fall;
   logic [31:0] timer_q;
   logic [3:0]  bit_cnt_q;
   logic [10:0] rx_sr_q;
   logic        tx_oe_q;
   logic        ack_seen_q;
   logic [3:0]  attempt_q;
   logic [2:0]  step_q;
   logic [2:0]  step_next;
   logic [7:0]  cmd_byte;
   logic        resp_tmo, bit_tmo, frame_ok, attempt_fail, listening;

   assign clk_s     = clk_sync[1];
   assign data_s    = data_sync[1];
   assign fall      = clk_prev & ~clk_s;
   assign resp_tmo  = timer_q >= RESP_LAST;
   assign bit_tmo   = timer_q >= BIT_LAST;
   assign step_next = step_q + 3'd1;
   assign cmd_byte  = script_byte(step_q);
   assign frame_ok  = !rx_sr_q[0] && (^rx_sr_q[9:1]) && rx_sr_q[10];
   assign listening = (state_q == S_TX) || (state_q == S_TX_ACK) || (state_q == S_RX);

   always_comb begin
      state_d      = state_q;
      attempt_fail = 1'b0;
      unique case (state_q)
         S_IDLE:    state_d = S_INHIBIT;
         S_INHIBIT: if (timer_q >= INHIBIT_LAST) state_d = S_RTS;
         S_RTS:     state_d = S_TX;
         S_TX: begin
            if (fall) begin
               if (bit_cnt_q == 4'd9) state_d = S_TX_ACK;
            end else if (resp_tmo) attempt_fail = 1'b1;
         end
         S_TX_ACK: begin
            if (!ack_seen_q) begin
               if (fall) attempt_fail = data_s;
               else if (resp_tmo) attempt_fail = 1'b1;
            end else if (clk_s && data_s) state_d = S_RX;
            else if (resp_tmo) attempt_fail = 1'b1;
         end
         S_RX: begin
            if (fall) begin
               if (bit_cnt_q == 4'd10) state_d = S_CHECK;
            end else if (resp_tmo) attempt_fail = 1'b1;
         end
         S_CHECK: begin
            if (!frame_ok || (rx_sr_q[8:1] != cmd_byte)) attempt_fail = 1'b1;
            else if (step_q == LAST_STEP) state_d = S_DONE;
            else if (script_is_cmd(step_next)) state_d = S_INHIBIT;
            else state_d = S_RX;
         end
         S_DONE:  state_d = S_DONE;
         S_FAIL:  state_d = S_FAIL;
         default: state_d = S_IDLE;
      endcase
      if (attempt_fail) state_d = (attempt_q < RETRY_MAX) ? S_IDLE : S_FAIL;
      if (reinit) state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         clk_sync   <= 2'b11;
         data_sync  <= 2'b11;
         clk_prev   <= 1'b1;
         timer_q    <= '0;
         bit_cnt_q  <= '0;
         rx_sr_q    <= '0;
         tx_oe_q    <= 1'b0;
         ack_seen_q <= 1'b0;
         attempt_q  <= '0;
         step_q     <= '0;
      end else begin
         state_q   <= state_d;
         clk_sync  <= {clk_sync[0], ps2_clk_in};
         data_sync <= {data_sync[0], ps2_data_in};
         clk_prev  <= clk_s;

         // Own clock pull during INHIBIT must not stretch the inhibit window
         if (state_d != state_q || (fall && listening)) timer_q <= '0;
         else if (timer_q != '1) timer_q <= timer_q + 32'd1;

         if (state_d != state_q) bit_cnt_q <= '0;
         else if (state_q == S_RX && !fall && bit_tmo && bit_cnt_q != 4'd0) bit_cnt_q <= '0;
         else if (fall && (state_q == S_TX || state_q == S_RX)) bit_cnt_q <= bit_cnt_q + 4'd1;

         if (state_q == S_RX && fall) rx_sr_q <= {data_s, rx_sr_q[10:1]};

         if (state_q == S_RTS) tx_oe_q <= 1'b1;
         else if (state_q == S_TX && fall) begin
            if (bit_cnt_q < 4'd8) tx_oe_q <= !cmd_byte[bit_cnt_q[2:0]];
            else if (bit_cnt_q == 4'd8) tx_oe_q <= ^cmd_byte;
            else tx_oe_q <= 1'b0;
         end

         if (state_d != state_q) ack_seen_q <= 1'b0;
         else if (state_q == S_TX_ACK && fall && !data_s) ack_seen_q <= 1'b1;

         if (reinit) attempt_q <= '0;
         else if (state_q == S_IDLE && attempt_q < RETRY_MAX) attempt_q <= attempt_q + 4'd1;

         if (state_q == S_IDLE) step_q <= '0;
         else if ((state_q == S_TX_ACK && state_d == S_RX) ||
                  (state_q == S_CHECK && (state_d == S_RX || state_d == S_INHIBIT)))
            step_q <= step_next;
      end
   end

   assign ps2_clk_oe   = (state_q == S_INHIBIT) || (state_q == S_RTS);
   assign ps2_data_oe  = (state_q == S_RTS) || (state_q == S_TX && tx_oe_q);
   assign init_done    = (state_q == S_DONE);
   assign init_error   = (state_q == S_FAIL);
   assign datapath_rst = !init_done;
   assign attempt_cnt  = attempt_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Bench for ps2_mouse_init_ctrl: a wired-AND PS/2 device model driving
// responses, with host frames checked against a queue of expected commands.
module tb_ps2_mouse_init_ctrl;
   localparam int H = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       reinit = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe, init_done, init_error, datapath_rst;
   logic [3:0] attempt_cnt, state_dbg;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];

   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   always #5 clk = ~clk;

   ps2_mouse_init_ctrl #(
      .INHIBIT_CYCLES(20), .RESP_TIMEOUT_CYCLES(500),
      .BIT_TIMEOUT_CYCLES(100), .MAX_RETRY(3)
   ) dut (
      .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .reinit(reinit), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .init_done(init_done), .init_error(init_error), .datapath_rst(datapath_rst),
      .attempt_cnt(attempt_cnt), .state_dbg(state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tx();
      int n = 0;
      while (!(ps2_data_oe && !ps2_clk_oe) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("wait_tx_timeout", 32'(n < 3000), 1);
   endtask

   // Device side of a host-to-device transfer, ACK bit chosen by caller
   task automatic host_frame(input logic ack_bit);
      logic [9:0] bits;
      logic       start;
      logic [7:0] exp;
      wait_tx();
      repeat (5) @(negedge clk);
      start = ps2_data_in;
      for (int k = 0; k < 10; k++) begin
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         bits[k] = ps2_data_in;
         dev_clk = 1'b1;
         repeat (H) @(negedge clk);
      end
      dev_data = ack_bit;
      dev_clk  = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (H) @(negedge clk);
      if (exp_q.size() == 0) check("host_frame_unexpected", 32'(bits[7:0]), 32'hDEAD);
      else begin
         exp = exp_q.pop_front();
         check("host_start", 32'(start), 0);
         check("host_byte", 32'(bits[7:0]), 32'(exp));
         check("host_parity", 32'(bits[8]), 32'(~^exp));
         check("host_stop", 32'(bits[9]), 1);
      end
   endtask

   task automatic dev_byte(input logic [7:0] b, input logic bad_par);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      repeat (2 * H) @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         dev_data = fr[i];
         repeat (H / 2) @(negedge clk);
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         dev_clk = 1'b1;
         repeat (H / 2) @(negedge clk);
      end
      dev_data = 1'b1;
   endtask

   task automatic good_tail();
      dev_byte(8'hFA, 1'b0);
      dev_byte(8'hAA, 1'b0);
      dev_byte(8'h00, 1'b0);
      exp_q.push_back(8'hF4);
      host_frame(1'b0);
      dev_byte(8'hFA, 1'b0);
   endtask

   task automatic wait_done(input logic [3:0] exp_attempts);
      int n = 0;
      while (!init_done && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", 32'(n < 500), 1);
      check("done_init_done", 32'(init_done), 1);
      check("done_dp_rst", 32'(datapath_rst), 0);
      check("done_attempts", 32'(attempt_cnt), 32'(exp_attempts));
      check("done_state", 32'(state_dbg), 7);
      check("done_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
   endtask

   task automatic do_reinit();
      @(negedge clk);
      reinit = 1'b1;
      @(negedge clk);
      reinit = 1'b0;
   endtask

   initial begin
      int n, hi_len, rts_cnt;
      logic prev_doe;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_clk_oe", 32'(ps2_clk_oe), 0);
      check("rst_data_oe", 32'(ps2_data_oe), 0);
      check("rst_done", 32'(init_done), 0);
      check("rst_error", 32'(init_error), 0);
      check("rst_dp_rst", 32'(datapath_rst), 1);
      check("rst_attempt", 32'(attempt_cnt), 0);
      check("rst_state", 32'(state_dbg), 0);

      // One IDLE cycle, then INHIBIT+RTS clock pull of 21 cycles
      reset = 1'b0;
      #1 check("idle_state", 32'(state_dbg), 0);
      @(negedge clk);
      check("inhibit_state", 32'(state_dbg), 1);
      check("inhibit_attempt", 32'(attempt_cnt), 1);
      hi_len = 0;
      n = 0;
      while (ps2_clk_oe && n < 100) begin
         hi_len++;
         if (hi_len == 20) check("inhibit_no_data", 32'(ps2_data_oe), 0);
         if (hi_len == 21) check("rts_data_oe", 32'(ps2_data_oe), 1);
         @(negedge clk);
         n++;
      end
      check("clk_oe_len", 32'(hi_len), 21);

      // Good device
      exp_q.push_back(8'hFF);
      host_frame(1'b0);
      good_tail();
      wait_done(4'd1);

      // reinit from DONE; first attempt gets FC in place of AA
      do_reinit();
      check("reinit_done", 32'(init_done), 0);
      check("reinit_dp_rst", 32'(datapath_rst), 1);
      check("reinit_attempt", 32'(attempt_cnt), 0);
      check("reinit_state", 32'(state_dbg), 0);
      exp_q.push_back(8'hFF);
      host_frame(1'b0);
      dev_byte(8'hFA, 1'b0);
      dev_byte(8'hFC, 1'b0);
      exp_q.push_back(8'hFF);
      host_frame(1'b0);
      good_tail();
      wait_done(4'd2);

      // Even-parity FA, then a missing ACK, then success on attempt 3
      do_reinit();
      exp_q.push_back(8'hFF);
      host_frame(1'b0);
      dev_byte(8'hFA, 1'b1);
      exp_q.push_back(8'hFF);
      host_frame(1'b1);
      exp_q.push_back(8'hFF);
      host_frame(1'b0);
      good_tail();
      wait_done(4'd3);

      // Reset after the 5th TX fall event
      do_reinit();
      wait_tx();
      repeat (5) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         dev_clk = 1'b1;
         repeat (H) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (6) @(negedge clk);
      check("pre_rst_state", 32'(state_dbg), 3);
      reset = 1'b1;
      #1;
      check("async_rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
      check("async_rst_state", 32'(state_dbg), 0);
      dev_clk = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("restart_state", 32'(state_dbg), 1);
      check("restart_attempt", 32'(attempt_cnt), 1);

      // Silent device: three RTS sequences then FAIL
      rts_cnt  = 0;
      prev_doe = 1'b0;
      n = 0;
      while (!init_error && n < 6000) begin
         if (ps2_data_oe && !prev_doe) rts_cnt++;
         prev_doe = ps2_data_oe;
         @(negedge clk);
         n++;
      end
      check("fail_timeout", 32'(n < 6000), 1);
      check("fail_rts_cnt", 32'(rts_cnt), 3);
      check("fail_error", 32'(init_error), 1);
      check("fail_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
      check("fail_attempt", 32'(attempt_cnt), 3);
      check("fail_state", 32'(state_dbg), 8);
      check("fail_done", 32'(init_done), 0);
      repeat (20) @(negedge clk);
      check("fail_sticky", 32'(init_error), 1);

      // reinit leaves FAIL
      do_reinit();
      check("fail_reinit_error", 32'(init_error), 0);
      check("fail_reinit_state", 32'(state_dbg), 0);
      check("fail_reinit_attempt", 32'(attempt_cnt), 0);

      check("sb_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ps2_mouse_init_ctrl.md
# ps2_mouse_init_ctrl

- Host-side bring-up sequencer for the PS/2 mouse port; sits between the PS/2 pins and the stream-mode mouse datapath.
- Resets the mouse (0xFF), checks its self-test/ID responses, enables data reporting (0xF4), and then hands the bus over.
- Drives the open-drain lines for host-to-device transfers and parses device-to-host response bytes itself.
- Holds the downstream packet datapath in reset until initialisation succeeds.

## Interface
- INHIBIT_CYCLES, 10000: clock-low inhibit before request-to-send (100 µs @ 100 MHz).
- RESP_TIMEOUT_CYCLES, 75000000: max wait for each expected event (device clock edge, response byte), 750 ms.
- BIT_TIMEOUT_CYCLES, 200000: max gap between falling edges inside one frame, 2 ms.
- MAX_RETRY, 3: total init attempts before giving up (1..15).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- ps2_clk_in  in  1  PS/2 clock pin level (asynchronous).
- ps2_data_in  in  1  PS/2 data pin level (asynchronous).
- reinit  in  1  one-cycle pulse: restart the full sequence.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release (top level drives the pin to 0 or z).
- ps2_data_oe  out  1  1 = pull PS/2 data low.
- init_done  out  1  mouse is streaming; datapath may consume packets.
- init_error  out  1  all attempts failed; sticky until reset/reinit.
- datapath_rst  out  1  reset to the packet datapath, equal to !init_done.
- attempt_cnt  out  4  attempts started in the current sequence.
- state_dbg  out  4  current state encoding, for seven-segment debug.

## Operation
- Input conditioning: both pins pass through a 2-FF synchroniser.
  - A falling edge of synchronised clock = fall event.
  - Data is sampled from synchronised data in the fall-event cycle.
- States (state_dbg code in brackets): IDLE(0), INHIBIT(1), RTS(2), TX(3), TX_ACK(4), RX(5), CHECK(6), DONE(7), FAIL(8).
- Command script, one attempt:
  - send 0xFF; expect 0xFA, then 0xAA, then 0x00.
  - send 0xF4; expect 0xFA.
  - then DONE.
- IDLE: increments attempt_cnt, loads the next command, then goes to INHIBIT.
- INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles, then RTS.
- RTS: one cycle with ps2_clk_oe=1 and ps2_data_oe=1 (start bit), then TX with ps2_clk_oe=0.
- TX: on each fall event, present the next bit on ps2_data_oe (oe = !bit).
  - Fall events 1–8 present d0..d7.
  - Fall event 9 presents the odd-parity bit.
  - Fall event 10 releases data (stop bit).
  - Then TX_ACK.
- TX_ACK: at the next fall event, sampled data must be 0 (device ACK), otherwise the attempt fails.
  - Then wait until both synchronised lines are high, then RX.
- RX: 11-bit frame on fall events — start(0), d0..d7 LSB first, odd parity, stop(1).
  - The bit counter clears if BIT_TIMEOUT_CYCLES elapse between fall events mid-frame.
  - The overall RX wait is bounded by RESP_TIMEOUT_CYCLES.
  - A complete frame goes to CHECK.
- CHECK:
  - A frame error (start≠0, parity even, or stop≠1), or a byte ≠ expected, fails the attempt.
  - A match advances to the next expected byte, or the next command, or DONE.
- Attempt failure (bad ACK, bad byte, frame error, any timeout):
  - Release both lines.
  - If attempt_cnt < MAX_RETRY, go to IDLE; otherwise go to FAIL.
- DONE: init_done=1, both oe=0; all bus traffic is ignored.
- FAIL: init_error=1, both oe=0.
- reinit:
  - Honoured in any state.
  - Clears attempt_cnt, init_done and init_error, releases both lines, and goes to IDLE next cycle.
  - reinit wins over any event in the same cycle.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, init_done=0, init_error=0, datapath_rst=1, attempt_cnt=0, state_dbg=0 (IDLE).
- Reset is asynchronous; asserting it mid-transfer releases both lines immediately.
- IDLE lasts 1 cycle after reset or reinit release.
- ps2_clk_oe rises the cycle after IDLE and stays high exactly INHIBIT_CYCLES+1 cycles (INHIBIT + RTS).
- ps2_data_oe rises in the RTS cycle.
- Pin-to-fall-event latency: 3 clk cycles.
- ps2_data_oe updates in the cycle after the fall event.
- Timeouts:
  - The timer restarts on every fall event and on every state entry.
  - Timeout fires when the count reaches the parameter value; the timer is 32 bits.
- CHECK lasts 1 cycle.
- init_done and datapath_rst change in the same cycle DONE is entered.
- attempt_cnt saturates at MAX_RETRY.

## Test plan
- Good device model (answers ACK, FA, AA 00, ACK, FA):
  - Host frames captured: 0xFF with parity 1, then 0xF4 with parity 0.
  - init_done=1, datapath_rst=0, attempt_cnt=1.
- Device answers 0xFC instead of 0xAA on attempt 1, then behaves:
  - Second 0xFF sent.
  - init_done=1 with attempt_cnt=2.
- Silent device with INHIBIT_CYCLES=20, RESP_TIMEOUT_CYCLES=500, MAX_RETRY=3:
  - Three RTS sequences, then FAIL.
  - init_error=1, both oe=0, attempt_cnt=3.
- Response 0xFA sent with even parity, or ACK bit left high:
  - Attempt fails and a fresh 0xFF follows.
- reinit pulse while in DONE:
  - Next cycle init_done=0, datapath_rst=1, attempt_cnt=0.
  - New 0xFF transfer begins.
- reset asserted after the 5th TX fall event:
  - ps2_clk_oe=ps2_data_oe=0 combinationally.
  - After release, the sequence restarts from INHIBIT with attempt_cnt=1.
